// File: rtl/booth_pkg.sv
// ---------------------------------------------------------------------------
// booth_pkg
//   Shared types and helpers for the sequential radix-4 Booth multiplier.
//   - state_t       : controller states (IDLE, RUN, DONE)
//   - booth_digit_t : one recoded radix-4 digit as {is_single, is_double, neg}
//   - digit_count() : number of radix-4 digits for an operand width and mode
// ---------------------------------------------------------------------------
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // is_single selects +/-A, is_double selects +/-2A, neither selects 0.
    typedef struct packed {
        logic is_single;
        logic is_double;
        logic neg;
    } booth_digit_t;

    // Unsigned operands need one extra digit so that the MSB of b is seen
    // through a positive top triplet {0, 0, b[WIDTH-1]}.
    function automatic int digit_count(input int width, input logic tc);
        return tc ? (width / 2) : (width / 2 + 1);
    endfunction

endpackage

// File: rtl/booth_digit_encoder.sv
// ---------------------------------------------------------------------------
// booth_digit_encoder
//   Combinational radix-4 Booth recoder for one multiplier triplet.
//   Ports:
//     triplet  in  3   {b[2i+1], b[2i], b[2i-1]}
//     digit    out     recoded digit {is_single, is_double, neg}
// ---------------------------------------------------------------------------
module booth_digit_encoder
    import booth_pkg::*;
(
    input  logic [2:0]   triplet,
    output booth_digit_t digit
);

    assign digit.is_single = triplet[1] ^ triplet[0];
    // +2A for 011, -2A for 100; every other pattern is 0 or +/-A.
    assign digit.is_double = ( triplet[2] & ~triplet[1] & ~triplet[0]) |
                             (~triplet[2] &  triplet[1] &  triplet[0]);
    assign digit.neg       = triplet[2];

endmodule

// File: rtl/booth_seq_multiplier.sv
// ---------------------------------------------------------------------------
// booth_seq_multiplier
//   Sequential radix-4 Booth multiplier. One multiplier digit is recoded and
//   accumulated per clock; the 2*WIDTH product is registered on completion.
//   WIDTH must be even and >= 4.
//   Ports:
//     clk      in   1         rising-edge clock
//     reset    in   1         synchronous, active-high reset
//     start    in   1         request a multiply (sampled while ready = 1)
//     tc       in   1         1 = two's-complement, 0 = unsigned operands
//     a        in   WIDTH     multiplicand
//     b        in   WIDTH     multiplier (Booth-recoded)
//     ready    out  1         block can accept start
//     done     out  1         one-cycle pulse, product valid
//     product  out  2*WIDTH   result, held until next accepted start/reset
// ---------------------------------------------------------------------------
module booth_seq_multiplier
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               tc,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               ready,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int PW    = 2 * WIDTH;          // product width
    localparam int XW    = WIDTH + 2;          // extended multiplicand width
    localparam int BW    = WIDTH + 3;          // {ext2, b, b[-1]}
    localparam int CNT_W = $clog2(WIDTH / 2 + 1);

    state_t             state;
    logic [XW-1:0]      a_q;
    logic [BW-1:0]      b_q;
    logic               tc_q;
    logic [CNT_W-1:0]   cnt;
    logic [PW-1:0]      acc;
    logic [PW-1:0]      product_q;

    logic [2:0]         triplet;
    booth_digit_t       digit;
    logic [CNT_W:0]     shamt;
    logic [XW-1:0]      pp_base;
    logic [XW-1:0]      pp_inv;
    logic [PW-1:0]      pp_ext;
    logic [PW-1:0]      acc_next;
    logic [CNT_W-1:0]   last_idx;

    // Digit i lives at b_q[2i+2:2i] because b_q[0] holds the implicit b[-1].
    assign shamt   = {cnt, 1'b0};
    assign triplet = 3'(b_q >> shamt);

    booth_digit_encoder u_encoder (
        .triplet (triplet),
        .digit   (digit)
    );

    // NOTE: every combinational output is assigned on every path through the
    // block, so no storage is implied; a missing default here would infer a latch.
    always_comb begin
        pp_base = '0;
        if (digit.is_double) begin
            pp_base = a_q << 1;
        end else if (digit.is_single) begin
            pp_base = a_q;
        end
        // Negation is one's complement here plus a carry-in added at the
        // same weight in the accumulator sum below.
        pp_inv   = digit.neg ? ~pp_base : pp_base;
        pp_ext   = {{(PW - XW){pp_inv[XW-1]}}, pp_inv};
        acc_next = acc + (pp_ext << shamt) + (PW'(digit.neg) << shamt);
        last_idx = CNT_W'(digit_count(WIDTH, tc_q) - 1);
    end

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            tc_q      <= 1'b0;
            cnt       <= '0;
            acc       <= '0;
            product_q <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_q   <= tc ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
                        // Upper two bits give the unsigned top digit {0,0,b[W-1]}
                        // and are never reached in signed mode.
                        b_q   <= {{2{tc & b[WIDTH-1]}}, b, 1'b0};
                        tc_q  <= tc;
                        cnt   <= '0;
                        acc   <= '0;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == last_idx) begin
                        product_q <= acc_next;
                        state     <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ready   = (state != RUN);
    assign done    = (state == DONE);
    assign product = product_q;

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// ---------------------------------------------------------------------------
// tb_booth_seq_multiplier
//   Self-checking bench for booth_seq_multiplier: directed vector table,
//   back-to-back, reset and start corner cases at WIDTH = 8, plus randomised
//   operands at WIDTH = 4, 8 and 16 in both modes.
// ---------------------------------------------------------------------------
module tb_booth_seq_multiplier;

    localparam int W = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          tc;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          ready;
    logic          done;
    logic [2*W-1:0] product;

    always #5 clk = ~clk;

    booth_seq_multiplier #(.WIDTH(W)) u_dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .tc      (tc),
        .a       (a),
        .b       (b),
        .ready   (ready),
        .done    (done),
        .product (product)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2*W-1:0] exp;
        int             start_cyc;
        int             lat;
    } sb_entry_t;

    typedef struct {
        logic           tc;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] exp;
    } vec_t;

    sb_entry_t sb_q[$];
    int        done_cycles[$];
    vec_t      vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference a*b modulo 2^(2w), operands interpreted per mode.
    function automatic logic [63:0] ref_mul(input int w, input logic tcm,
                                            input logic [31:0] x, input logic [31:0] y);
        longint mask_in, sx, sy, p;
        mask_in = (longint'(1) << w) - 1;
        sx = longint'(x) & mask_in;
        sy = longint'(y) & mask_in;
        if (tcm && x[w-1]) sx -= longint'(1) << w;
        if (tcm && y[w-1]) sy -= longint'(1) << w;
        p = sx * sy;
        return 64'(p) & ((64'(1) << (2 * w)) - 1);
    endfunction

    // Scoreboard consumer: every done pulse must match the oldest expectation.
    initial begin
        sb_entry_t e;
        forever begin
            @(negedge clk);
            if (done) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("product", product, e.exp);
                    check("latency", cyc - e.start_cyc, e.lat);
                    done_cycles.push_back(cyc);
                end
            end
        end
    end

    // Called at a negedge where ready = 1: the next edge accepts the request.
    task automatic issue(input logic t, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [2*W-1:0] e);
        tc    = t;
        a     = x;
        b     = y;
        start = 1'b1;
        sb_q.push_back('{e, cyc, (t ? W / 2 : W / 2 + 1) + 1});
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && sb_q.size() > 0; i++) @(negedge clk);
        check("done_timeout", sb_q.size(), 0);
    endtask

    task automatic run_op(input logic t, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [2*W-1:0] e);
        @(negedge clk);
        issue(t, x, y, e);
        @(negedge clk);
        start = 1'b0;
        // Operands are free to change once accepted.
        a  = W'($urandom);
        b  = W'($urandom);
        tc = ~t;
        wait_idle(20);
    endtask

    // Randomised runs at other widths, each with its own DUT instance.
    for (genvar g = 0; g < 2; g++) begin : g_rnd
        localparam int GW = (g == 0) ? 4 : 16;

        logic            r_reset = 1'b1;
        logic            r_start = 1'b0;
        logic            r_tc    = 1'b0;
        logic [GW-1:0]   r_a     = '0;
        logic [GW-1:0]   r_b     = '0;
        logic            r_ready;
        logic            r_done;
        logic [2*GW-1:0] r_product;
        logic            fin     = 1'b0;

        booth_seq_multiplier #(.WIDTH(GW)) u_dut (
            .clk     (clk),
            .reset   (r_reset),
            .start   (r_start),
            .tc      (r_tc),
            .a       (r_a),
            .b       (r_b),
            .ready   (r_ready),
            .done    (r_done),
            .product (r_product)
        );

        initial begin
            logic [63:0]   r;
            logic          t;
            logic [GW-1:0] x;
            logic [GW-1:0] y;
            int            start_c;
            repeat (3) @(negedge clk);
            r_reset = 1'b0;
            check(GW == 4 ? "w4_reset_ready" : "w16_reset_ready", r_ready, 1);
            for (int k = 0; k < 30; k++) begin
                t = 1'($urandom);
                x = GW'($urandom);
                y = GW'($urandom);
                r = ref_mul(GW, t, 32'(x), 32'(y));
                @(negedge clk);
                r_tc    = t;
                r_a     = x;
                r_b     = y;
                r_start = 1'b1;
                start_c = cyc;
                @(negedge clk);
                r_start = 1'b0;
                r_a     = GW'($urandom);
                while (!r_done && (cyc - start_c) < 40) @(negedge clk);
                check(GW == 4 ? "w4_latency" : "w16_latency",
                      cyc - start_c, (t ? GW / 2 : GW / 2 + 1) + 1);
                check(GW == 4 ? "w4_product" : "w16_product", r_product, r[2*GW-1:0]);
            end
            fin = 1'b1;
        end
    end

    initial begin
        logic [2*W-1:0] last_exp;
        logic [63:0]    r;
        logic           t;
        logic [W-1:0]   x;
        logic [W-1:0]   y;
        vec_t           bb[3];
        int             idx;

        vecs[0]  = '{1'b1, 8'h07, 8'hFD, 16'hFFEB};
        vecs[1]  = '{1'b1, 8'h80, 8'h80, 16'h4000};
        vecs[2]  = '{1'b1, 8'h80, 8'h7F, 16'hC080};
        vecs[3]  = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
        vecs[4]  = '{1'b0, 8'h00, 8'hC8, 16'h0000};
        vecs[5]  = '{1'b1, 8'hFF, 8'hFF, 16'h0001};
        vecs[6]  = '{1'b0, 8'h80, 8'h02, 16'h0100};
        vecs[7]  = '{1'b1, 8'h7F, 8'h7F, 16'h3F01};
        vecs[8]  = '{1'b0, 8'h01, 8'hFF, 16'h00FF};
        vecs[9]  = '{1'b1, 8'hFF, 8'h01, 16'hFFFF};
        vecs[10] = '{1'b0, 8'h80, 8'h80, 16'h4000};
        vecs[11] = '{1'b1, 8'h80, 8'h01, 16'hFF80};

        bb[0] = '{1'b1, 8'd11, 8'd13, 16'h008F};
        bb[1] = '{1'b1, 8'hFB, 8'd9,  16'hFFD3};
        bb[2] = '{1'b1, 8'h64, 8'h9C, 16'hD8F0};

        reset = 1'b1;
        start = 1'b0;
        tc    = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        check("reset_ready", ready, 1);
        check("reset_done", done, 0);
        check("reset_product", product, 0);
        reset = 1'b0;

        // Directed vectors; product must also hold after the done pulse.
        last_exp = '0;
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].tc, vecs[i].a, vecs[i].b, vecs[i].exp);
            repeat (2) @(negedge clk);
            check("product_held", product, vecs[i].exp);
            last_exp = vecs[i].exp;
        end

        // Previous result stays visible while the next multiply runs.
        @(negedge clk);
        issue(1'b1, 8'd3, 8'd5, 16'h000F);
        @(negedge clk);
        start = 1'b0;
        check("run_ready_low", ready, 0);
        check("run_product_hold", product, last_exp);
        wait_idle(20);

        // start held high: back-to-back ops, junk inputs and starts during RUN.
        done_cycles.delete();
        idx = 0;
        for (int c = 0; c < 40 && idx < 3; c++) begin
            @(negedge clk);
            if (ready) begin
                issue(bb[idx].tc, bb[idx].a, bb[idx].b, bb[idx].exp);
                idx++;
            end else begin
                a  = W'($urandom);
                b  = W'($urandom);
                tc = 1'($urandom);
            end
        end
        @(negedge clk);
        start = 1'b0;
        wait_idle(30);
        check("b2b_done_count", done_cycles.size(), 3);
        if (done_cycles.size() == 3) begin
            check("b2b_spacing_1", done_cycles[1] - done_cycles[0], 5);
            check("b2b_spacing_2", done_cycles[2] - done_cycles[1], 5);
        end

        // reset and start together: reset wins.
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        tc    = 1'b1;
        a     = 8'd9;
        b     = 8'd9;
        @(negedge clk);
        check("rst_start_ready", ready, 1);
        reset = 1'b0;
        start = 1'b0;

        // Reset two cycles into RUN discards the operation.
        @(negedge clk);
        issue(1'b1, 8'h07, 8'hFD, 16'hFFEB);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        sb_q.delete();
        @(negedge clk);
        check("midrun_rst_ready", ready, 1);
        check("midrun_rst_product", product, 0);
        check("midrun_rst_done", done, 0);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        run_op(1'b0, 8'd200, 8'd3, 16'h0258);

        // Randomised at WIDTH = 8.
        for (int k = 0; k < 40; k++) begin
            t = 1'($urandom);
            x = W'($urandom);
            y = W'($urandom);
            r = ref_mul(W, t, 32'(x), 32'(y));
            run_op(t, x, y, r[2*W-1:0]);
        end

        for (int i = 0; i < 5000 && !(g_rnd[0].fin && g_rnd[1].fin); i++) @(negedge clk);
        check("rand_widths_finished", {g_rnd[0].fin, g_rnd[1].fin}, 2'b11);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
